figo_controller: RTL and testbench
==================================

# figo_controller

Four-room sequencing FSM for the Figo navigation path. A serial command bit stream on `input_data` is grouped into 2-bit symbols. Each symbol that matches the key of the current room advances the controller to the next room (Room0→1→2→3→0). `next_state` reports the registered room for downstream display and actuation logic. An optional synchronous load through `current_state` lets a supervisor force a room.

## Interface
- No parameters.
- `clk` input 1: single clock, rising-edge active.
- `reset` input 1: asynchronous, active-low reset.
- `input_data` input 1: serial command bit, sampled on every rising `clk` edge.
- `current_state` input 3: supervisor load request. Bit 2 = load strobe; bits 1:0 = target room.
- `next_state` output 3: registered current room, {1'b0, room[1:0]}.

## Operation
- Internal state:
  - `room[1:0]`: Room0=0, Room1=1, Room2=2, Room3=3.
  - `phase`: 0 = expecting the first bit of a symbol, 1 = expecting the second bit.
  - `first_bit`: captured first bit.
- Symbol forming:
  - phase 0 edge: capture `input_data` into `first_bit`; set phase to 1.
  - phase 1 edge: symbol = {`first_bit`, `input_data`}; evaluate; set phase to 0.
- Room keys and transitions (evaluated only on phase 1 edges):
  - Room0: symbol 2'b10 → Room1.
  - Room1: symbol 2'b00 → Room2.
  - Room2: symbol 2'b11 → Room3.
  - Room3: symbol 2'b01 → Room0 (wrap).
  - Any other symbol: room unchanged; no error state.
- Supervisor load:
  - If `current_state[2]`=1 at an edge: `room` ← `current_state[1:0]`, phase ← 0, `first_bit` ← 0.
  - Load has priority over symbol evaluation at that edge.
  - `current_state[2]`=0: `current_state` is ignored.
- Output: `next_state` = {1'b0, room}. Registered, with no combinational path from inputs. `next_state[2]` is always 0.
- Encodings 3'b1xx are never produced.

## Timing
- Reset asserted (`reset`=0): immediately and asynchronously sets room=0, phase=0, `first_bit`=0, so `next_state`=3'b000. This holds while `reset` stays low, including mid-symbol, and any partial symbol is discarded.
- Reset release: the first rising edge with `reset`=1 is a phase 0 edge and captures the first bit.
- Latency: the room updates on the edge that samples the second bit of a matching symbol. `next_state` reflects the new room after that edge, i.e. 2 cycles per room step.
- Load latency: 1 cycle; `next_state` shows the target room after the loading edge.
- Symbols are framed strictly by phase from reset or load. There is no resynchronization on mismatches.
- Throughput: at most one room transition per 2 cycles. A full lap takes 8 cycles with correct keys.

## Test plan
- Reset: hold `reset`=0 with random `input_data` → `next_state`=3'b000 throughout. Assert `reset`=0 mid-symbol in Room2 → `next_state`=3'b000 immediately, before the next edge.
- Full lap: after release, drive bits 1,0, 0,0, 1,1, 0,1 on successive edges with `current_state`=3'b000. Required `next_state` after each symbol: 001, 010, 011, 000.
- Wrong keys: in Room0 drive 0,0 then 1,1 then 0,1 → `next_state` stays 000. Then drive 1,0 → 001.
- Framing: after release drive 0,1,0 (a misaligned "10"), then 0 → both symbols (01, 00) mismatch Room0, so `next_state` stays 000.
- Load: in Room1 mid-symbol, drive `current_state`=3'b111 for one edge → `next_state`=011 after that edge with phase reset. Then drive 0,1 → `next_state`=000.
- Load ignored: `current_state`=3'b011 (strobe=0) while in Room0 → no change. The lap sequence still behaves as in the full-lap scenario.

Source files
------------

// File: rtl/figo_controller.sv
// figo_controller: four-room sequencer that advances one room per matching
// 2-bit serial symbol, with a supervisor load that forces a room.
module figo_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       input_data,
    input  logic [2:0] current_state,
    output logic [2:0] next_state
);
    typedef enum logic [1:0] {ROOM0, ROOM1, ROOM2, ROOM3} room_t;
    room_t      room, room_nxt;
    logic       phase, phase_nxt;
    logic       first_bit, first_bit_nxt;
    logic [1:0] symbol, key;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            room      <= ROOM0;
            phase     <= 1'b0;
            first_bit <= 1'b0;
        end else begin
            room      <= room_nxt;
            phase     <= phase_nxt;
            first_bit <= first_bit_nxt;
        end
    end
    always_comb begin
        symbol        = {first_bit, input_data};
        key           = room == ROOM0 ? 2'b10 : room == ROOM1 ? 2'b00 : room == ROOM2 ? 2'b11 : 2'b01;
        room_nxt      = room;
        phase_nxt     = ~phase;
        first_bit_nxt = phase ? first_bit : input_data;
        if (phase && symbol == key)
            room_nxt = room_t'(room + 2'd1);
        // A load discards any partial symbol so framing restarts cleanly.
        if (current_state[2]) begin
            room_nxt      = room_t'(current_state[1:0]);
            phase_nxt     = 1'b0;
            first_bit_nxt = 1'b0;
        end
    end
    assign next_state = {1'b0, room};
endmodule

// File: tb/tb_figo_controller.sv
// tb_figo_controller: directed scoreboard bench for the four-room sequencer.
module tb_figo_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       input_data = 1'b0;
    logic [2:0] current_state = 3'b000;
    logic [2:0] next_state;
    logic [2:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    figo_controller dut (
        .clk(clk),
        .reset(reset),
        .input_data(input_data),
        .current_state(current_state),
        .next_state(next_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        logic [2:0] expv;
        expv = exp_q.pop_front();
        n_checks++;
        assert (next_state === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, next_state, expv);
        end
    endtask

    task automatic step(input logic d, input logic [2:0] cs, input logic [2:0] expv, input string tag);
        input_data    = d;
        current_state = cs;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic lap(input logic [2:0] cs, input string tag);
        logic [7:0] bits;
        logic [2:0] ex[8];
        bits = 8'b1000_1101;
        ex   = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0};
        for (int i = 0; i < 8; i++)
            step(bits[7-i], cs, ex[i], tag);
    endtask

    initial begin
        #3;
        exp_q.push_back(3'b000);
        check("reset_initial");
        for (int i = 0; i < 4; i++)
            step(1'($urandom_range(0, 1)), 3'b000, 3'b000, "reset_held");
        reset = 1'b1;
        lap(3'b000, "full_lap");
        step(0, 3'b000, 3'd0, "wrong_00a");
        step(0, 3'b000, 3'd0, "wrong_00b");
        step(1, 3'b000, 3'd0, "wrong_11a");
        step(1, 3'b000, 3'd0, "wrong_11b");
        step(0, 3'b000, 3'd0, "wrong_01a");
        step(1, 3'b000, 3'd0, "wrong_01b");
        step(1, 3'b000, 3'd0, "right_10a");
        step(0, 3'b000, 3'd1, "right_10b");
        step(0, 3'b000, 3'd1, "load_midsym");
        step(1, 3'b111, 3'd3, "load_edge");
        step(0, 3'b000, 3'd3, "after_load_a");
        step(1, 3'b000, 3'd0, "after_load_b");
        reset = 1'b0;
        #1;
        exp_q.push_back(3'b000);
        check("reset_pulse");
        reset = 1'b1;
        step(0, 3'b000, 3'd0, "framing_a");
        step(1, 3'b000, 3'd0, "framing_b");
        step(0, 3'b000, 3'd0, "framing_c");
        step(0, 3'b000, 3'd0, "framing_d");
        lap(3'b011, "load_ignored_lap");
        step(1, 3'b000, 3'd0, "to_r2_a");
        step(0, 3'b000, 3'd1, "to_r2_b");
        step(0, 3'b000, 3'd1, "to_r2_c");
        step(0, 3'b000, 3'd2, "to_r2_d");
        step(1, 3'b000, 3'd2, "r2_midsym");
        reset = 1'b0;
        #1;
        exp_q.push_back(3'b000);
        check("async_reset_midsym");
        step(1, 3'b000, 3'd0, "reset_hold_edge");
        reset = 1'b1;
        step(1, 3'b000, 3'd0, "release_phase0");
        step(0, 3'b000, 3'd1, "release_phase1");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
